perf_counter_bank: RTL and testbench

Parametrised successor to the CPU's fixed 16-bit branch statistics (unconditional / conditional / conditional-taken counters and the unused total_cycle display input). It provides N configurable event counters with a run/halt state machine, selectable saturate or wrap behaviour, and an atomic snapshot buffer. The seven-segment display path reads the snapshot buffer through a channel select, so it never shows torn values. It sits beside the datapath in mips_cpu: it is clocked by clk, qualified by a tick enable (the clk_run rate), and stopped by the syscall-exit event.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/perf_counter_bank_if.sv | 26 ++
 rtl/perf_counter_cell.sv | 29 ++
 rtl/perf_counter_bank.sv | 57 +++++
 tb/tb_perf_counter_bank.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, counter width default and channel indices for the perf counter bank
// Holds ST_* codes for state_o, the state_t enum used by the FSM, and CH_* display channel indices.
package cpu_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_RUN = ST_RUN, S_HALT = ST_HALT} state_t;
  localparam int CNT_W_DEF = 32;
  localparam int CH_CYCLE = 0;
  localparam int CH_UNCOND = 1;
  localparam int CH_COND = 2;
  localparam int CH_COND_TAKEN = 3;
endpackage

// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: control and readout bundle between the CPU datapath and the counter bank
// master drives tick/start/halt/clr/inc/snap/rd_sel and observes rd_data/sat_flags/state_o; slave is the bank.
interface perf_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int SEL_W = 2
);
  logic tick;
  logic start;
  logic halt;
  logic clr;
  logic snap;
  logic [NUM_CH-1:0] inc;
  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [NUM_CH-1:0] sat_flags;
  logic [1:0] state_o;
  modport master (
    output tick, start, halt, clr, snap, inc, rd_sel,
    input rd_data, sat_flags, state_o
  );
  modport slave (
    input tick, start, halt, clr, snap, inc, rd_sel,
    output rd_data, sat_flags, state_o
  );
endinterface

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one CNT_W event counter with saturate-or-wrap overflow and a sticky all-ones flag
// Ports: clk, rst (async, active-high), clr (sync clear), en (counting qualifier), inc (event),
//        cnt (count value), sat (sticky: cnt has reached all-ones).
module perf_counter_cell #(
  parameter int CNT_W = 32,
  parameter bit SAT_MODE = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  input logic inc,
  output logic [CNT_W-1:0] cnt,
  output logic sat
);
  logic [CNT_W-1:0] nxt;
  assign nxt = (SAT_MODE && &cnt) ? cnt : cnt + CNT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (en && inc) begin
      cnt <= nxt;
      sat <= sat | (&nxt);
    end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with IDLE/RUN/HALTED control and an atomic snapshot readout
// Ports: clk, rst (async, active-high); bus (slave modport) takes tick/start/halt/clr/inc/snap/rd_sel
//        and returns rd_data (snapshot[rd_sel], 0 when out of range), sat_flags and state_o.
module perf_counter_bank
  import cpu_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter bit SAT_MODE = 1'b1,
  parameter bit CYCLE_CH0 = 1'b1,
  parameter int SEL_W = 2
) (
  input logic clk,
  input logic rst,
  perf_counter_bank_if.slave bus
);
  state_t state, nxt;
  logic en, to_halt, pend;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] snapshot [NUM_CH];
  logic [NUM_CH-1:0] sat;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    to_halt = !bus.clr && state == S_RUN && bus.halt && bus.tick;
    nxt = bus.clr ? S_IDLE : to_halt ? S_HALT : (state == S_IDLE && bus.start) ? S_RUN : state;
    en = state == S_RUN && bus.tick;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter_cell #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_cell (
      .clk(clk),
      .rst(rst),
      .clr(bus.clr),
      .en(en),
      .inc((i == CH_CYCLE && CYCLE_CH0) ? 1'b1 : bus.inc[i]),
      .cnt(cnt[i]),
      .sat(sat[i])
    );
  end
  // The halt edge itself still updates the counters, so the auto-snapshot is taken
  // one edge later from the now-frozen values.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      snapshot <= '{default: '0};
    end else if (bus.clr) begin
      pend <= 1'b0;
      snapshot <= '{default: '0};
    end else begin
      pend <= to_halt;
      if (bus.snap || pend) snapshot <= cnt;
    end
  assign bus.rd_data = (int'(bus.rd_sel) < NUM_CH) ? snapshot[bus.rd_sel] : '0;
  assign bus.sat_flags = sat;
  assign bus.state_o = state;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and randomized checks of four perf_counter_bank configurations against a behavioural model
module tb_perf_counter_bank;
  import cpu_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic tick = 1'b0, start = 1'b0, halt = 1'b0, clr = 1'b0, snap = 1'b0;
  logic [3:0] inc = '0;
  logic [1:0] rd_sel = '0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  perf_counter_bank_if #(.NUM_CH(4), .CNT_W(32), .SEL_W(2)) bus_a ();
  perf_counter_bank_if #(.NUM_CH(4), .CNT_W(8), .SEL_W(2)) bus_s ();
  perf_counter_bank_if #(.NUM_CH(4), .CNT_W(8), .SEL_W(2)) bus_w ();
  perf_counter_bank_if #(.NUM_CH(3), .CNT_W(16), .SEL_W(2)) bus_n ();
  assign {bus_a.tick, bus_a.start, bus_a.halt, bus_a.clr, bus_a.snap, bus_a.inc, bus_a.rd_sel} = {tick, start, halt, clr, snap, inc, rd_sel};
  assign {bus_s.tick, bus_s.start, bus_s.halt, bus_s.clr, bus_s.snap, bus_s.inc, bus_s.rd_sel} = {tick, start, halt, clr, snap, inc, rd_sel};
  assign {bus_w.tick, bus_w.start, bus_w.halt, bus_w.clr, bus_w.snap, bus_w.inc, bus_w.rd_sel} = {tick, start, halt, clr, snap, inc, rd_sel};
  assign {bus_n.tick, bus_n.start, bus_n.halt, bus_n.clr, bus_n.snap, bus_n.inc, bus_n.rd_sel} = {tick, start, halt, clr, snap, inc[2:0], rd_sel};
  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SAT_MODE(1'b1), .CYCLE_CH0(1'b1), .SEL_W(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1'b1), .CYCLE_CH0(1'b1), .SEL_W(2)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1'b0), .CYCLE_CH0(1'b1), .SEL_W(2)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));
  perf_counter_bank #(.NUM_CH(3), .CNT_W(16), .SAT_MODE(1'b1), .CYCLE_CH0(1'b0), .SEL_W(2)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
  logic [31:0] obs_rd [4];
  logic [3:0] obs_sat [4];
  logic [1:0] obs_st [4];
  assign obs_rd[0] = bus_a.rd_data;
  assign obs_rd[1] = {24'b0, bus_s.rd_data};
  assign obs_rd[2] = {24'b0, bus_w.rd_data};
  assign obs_rd[3] = {16'b0, bus_n.rd_data};
  assign obs_sat[0] = bus_a.sat_flags;
  assign obs_sat[1] = bus_s.sat_flags;
  assign obs_sat[2] = bus_w.sat_flags;
  assign obs_sat[3] = {1'b0, bus_n.sat_flags};
  assign obs_st[0] = bus_a.state_o;
  assign obs_st[1] = bus_s.state_o;
  assign obs_st[2] = bus_w.state_o;
  assign obs_st[3] = bus_n.state_o;
  int nch [4] = '{4, 4, 4, 3};
  int wid [4] = '{32, 8, 8, 16};
  bit satm [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit cyc0 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  longint m_cnt [4][4];
  longint m_snap [4][4];
  logic [3:0] m_sat [4];
  logic [1:0] m_st;
  bit m_pend;
  longint saved [4][4];
  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_sat[k] = '0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0;
        m_snap[k][i] = 0;
      end
    end
    m_st = ST_IDLE;
    m_pend = 1'b0;
  endfunction
  function automatic logic [31:0] exp_rd(int k, logic [1:0] sel);
    return (int'(sel) < nch[k]) ? 32'(m_snap[k][sel]) : 32'd0;
  endfunction
  always @(posedge clk) begin
    longint mx;
    if (!rst) begin
      if (clr) model_reset();
      else begin
        for (int k = 0; k < 4; k++)
          for (int i = 0; i < nch[k]; i++) begin
            mx = (longint'(1) << wid[k]) - 1;
            if (snap || m_pend) m_snap[k][i] = m_cnt[k][i];
            if (m_st == ST_RUN && tick && (inc[i] || (i == 0 && cyc0[k]))) begin
              m_cnt[k][i] = (m_cnt[k][i] == mx) ? (satm[k] ? mx : 0) : m_cnt[k][i] + 1;
              if (m_cnt[k][i] == mx) m_sat[k][i] = 1'b1;
            end
          end
        m_pend = m_st == ST_RUN && tick && halt;
        m_st = m_pend ? ST_HALT : (m_st == ST_IDLE && start) ? ST_RUN : m_st;
      end
    end
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (obs_st[k] !== ST_IDLE) begin errs++; $display("FAIL reset_init_state dut%0d got=%b want=%b", k, obs_st[k], ST_IDLE); end
      if (obs_rd[k] !== 32'd0) begin errs++; $display("FAIL reset_init_rd dut%0d got=%0h want=0", k, obs_rd[k]); end
      if (obs_sat[k] !== 4'd0) begin errs++; $display("FAIL reset_init_sat dut%0d got=%b want=0", k, obs_sat[k]); end
    end
    #1 rst = 1'b0;
    step(1);
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1; inc = 4'b1111; step(260);
    tick = 1'b0; inc = '0; snap = 1'b1; step(1); snap = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (obs_rd[k] !== exp_rd(k, rd_sel)) begin errs++; $display("FAIL prereset_rd dut%0d got=%0h want=%0h", k, obs_rd[k], exp_rd(k, rd_sel)); end
      if (obs_sat[k] !== m_sat[k]) begin errs++; $display("FAIL prereset_sat dut%0d got=%b want=%b", k, obs_sat[k], m_sat[k]); end
      if (obs_st[k] !== ST_RUN) begin errs++; $display("FAIL prereset_state dut%0d got=%b want=%b", k, obs_st[k], ST_RUN); end
    end
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (obs_st[k] !== ST_IDLE) begin errs++; $display("FAIL async_reset_state dut%0d got=%b want=%b", k, obs_st[k], ST_IDLE); end
      if (obs_rd[k] !== 32'd0) begin errs++; $display("FAIL async_reset_rd dut%0d got=%0h want=0", k, obs_rd[k]); end
      if (obs_sat[k] !== 4'd0) begin errs++; $display("FAIL async_reset_sat dut%0d got=%b want=0", k, obs_sat[k]); end
    end
    model_reset();
    #2 rst = 1'b0;
    step(1);
  endtask
  task automatic test_count();
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1; inc = 4'b0110; step(10);
    tick = 1'b0; inc = '0; snap = 1'b1; step(1); snap = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_rd[k] !== exp_rd(k, rd_sel)) begin errs++; $display("FAIL count_rd dut%0d sel%0d got=%0h want=%0h", k, s, obs_rd[k], exp_rd(k, rd_sel)); end
      end
    end
    rd_sel = 2'd1; #1;
    checks++;
    if (obs_rd[0] !== 32'd10) begin errs++; $display("FAIL count_ch1 got=%0d want=10", obs_rd[0]); end
    rd_sel = 2'd0; #1;
    checks++;
    if (obs_rd[0] !== 32'd10) begin errs++; $display("FAIL count_cycle_ch0 got=%0d want=10", obs_rd[0]); end
    rd_sel = 2'd3; #1;
    checks++;
    if (obs_rd[0] !== 32'd0) begin errs++; $display("FAIL count_ch3 got=%0d want=0", obs_rd[0]); end
  endtask
  task automatic test_halt();
    clr = 1'b1; step(1); clr = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1; step(5);
    halt = 1'b1; inc = 4'b1000; step(1); halt = 1'b0; inc = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_st[k] !== ST_HALT) begin errs++; $display("FAIL halt_state dut%0d got=%b want=%b", k, obs_st[k], ST_HALT); end
    end
    step(1);
    rd_sel = 2'd3; #1;
    checks++;
    if (obs_rd[0] !== 32'd1) begin errs++; $display("FAIL halt_autosnap_ch3 got=%0d want=1", obs_rd[0]); end
    rd_sel = 2'd0; #1;
    checks++;
    if (obs_rd[0] !== 32'd6) begin errs++; $display("FAIL halt_autosnap_ch0 got=%0d want=6", obs_rd[0]); end
    inc = 4'b1111; start = 1'b1; halt = 1'b1; step(8);
    snap = 1'b1; step(1);
    snap = 1'b0; start = 1'b0; halt = 1'b0; inc = '0; tick = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_rd[k] !== exp_rd(k, rd_sel)) begin errs++; $display("FAIL halt_frozen_rd dut%0d sel%0d got=%0h want=%0h", k, s, obs_rd[k], exp_rd(k, rd_sel)); end
      end
    end
    rd_sel = 2'd0; #1;
    checks += 2;
    if (obs_rd[0] !== 32'd6) begin errs++; $display("FAIL halt_frozen_ch0 got=%0d want=6", obs_rd[0]); end
    if (obs_st[0] !== ST_HALT) begin errs++; $display("FAIL halt_sticky_state got=%b want=%b", obs_st[0], ST_HALT); end
  endtask
  task automatic test_overflow();
    clr = 1'b1; step(1); clr = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1; inc = 4'b0010; step(254);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_sat[k] !== m_sat[k]) begin errs++; $display("FAIL ovf_sat_254 dut%0d got=%b want=%b", k, obs_sat[k], m_sat[k]); end
    end
    checks++;
    if (obs_sat[1][1] !== 1'b0) begin errs++; $display("FAIL ovf_sat_early got=%b want=0", obs_sat[1][1]); end
    step(1);
    checks += 2;
    if (obs_sat[1][1] !== 1'b1) begin errs++; $display("FAIL ovf_sat_set_s got=%b want=1", obs_sat[1][1]); end
    if (obs_sat[2][1] !== 1'b1) begin errs++; $display("FAIL ovf_sat_set_w got=%b want=1", obs_sat[2][1]); end
    step(45);
    tick = 1'b0; inc = '0; snap = 1'b1; step(1); snap = 1'b0;
    rd_sel = 2'd1; #1;
    checks += 4;
    if (obs_rd[1] !== 32'd255) begin errs++; $display("FAIL ovf_saturate got=%0d want=255", obs_rd[1]); end
    if (obs_rd[2] !== 32'd44) begin errs++; $display("FAIL ovf_wrap got=%0d want=44", obs_rd[2]); end
    if (obs_rd[0] !== 32'd300) begin errs++; $display("FAIL ovf_wide got=%0d want=300", obs_rd[0]); end
    if (obs_sat[2][1] !== 1'b1) begin errs++; $display("FAIL ovf_sat_sticky_w got=%b want=1", obs_sat[2][1]); end
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_rd[k] !== exp_rd(k, rd_sel)) begin errs++; $display("FAIL ovf_rd dut%0d got=%0h want=%0h", k, obs_rd[k], exp_rd(k, rd_sel)); end
      if (obs_sat[k] !== m_sat[k]) begin errs++; $display("FAIL ovf_sat dut%0d got=%b want=%b", k, obs_sat[k], m_sat[k]); end
    end
  endtask
  task automatic test_snap_clr();
    tick = 1'b1;
    for (int c = 0; c < 8; c++) begin inc = 4'($urandom); step(1); end
    tick = 1'b0; snap = 1'b1; clr = 1'b1; step(1); snap = 1'b0; clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_rd[k] !== 32'd0) begin errs++; $display("FAIL snapclr_rd dut%0d sel%0d got=%0h want=0", k, s, obs_rd[k]); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_st[k] !== ST_IDLE) begin errs++; $display("FAIL snapclr_state dut%0d got=%b want=%b", k, obs_st[k], ST_IDLE); end
      if (obs_sat[k] !== 4'd0) begin errs++; $display("FAIL snapclr_sat dut%0d got=%b want=0", k, obs_sat[k]); end
    end
  endtask
  task automatic test_tick_gate();
    start = 1'b1; step(1); start = 1'b0;
    tick = 1'b1;
    for (int c = 0; c < 12; c++) begin inc = 4'($urandom); step(1); end
    tick = 1'b0; inc = 4'hf; snap = 1'b1; step(1); snap = 1'b0;
    saved = m_snap;
    step(20);
    snap = 1'b1; step(1); snap = 1'b0; inc = '0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_rd[k] !== ((s < nch[k]) ? 32'(saved[k][s]) : 32'd0)) begin errs++; $display("FAIL tickgate_rd dut%0d sel%0d got=%0h want=%0h", k, s, obs_rd[k], (s < nch[k]) ? 32'(saved[k][s]) : 32'd0); end
      end
    end
    checks += 2;
    if (obs_rd[3] !== 32'd0) begin errs++; $display("FAIL narrow_sel_oob got=%0h want=0", obs_rd[3]); end
    if (obs_st[0] !== ST_RUN) begin errs++; $display("FAIL tickgate_state got=%b want=%b", obs_st[0], ST_RUN); end
  endtask
  task automatic test_random();
    clr = 1'b1; step(1); clr = 1'b0;
    for (int c = 0; c < 800; c++) begin
      tick = ($urandom_range(3) != 0);
      start = ($urandom_range(5) == 0);
      halt = ($urandom_range(40) == 0);
      clr = ($urandom_range(80) == 0);
      snap = ($urandom_range(4) == 0);
      inc = 4'($urandom);
      rd_sel = 2'($urandom);
      step(1);
      for (int k = 0; k < 4; k++) begin
        checks += 3;
        if (obs_rd[k] !== exp_rd(k, rd_sel)) begin errs++; $display("FAIL rand_rd c%0d dut%0d sel%0d got=%0h want=%0h", c, k, rd_sel, obs_rd[k], exp_rd(k, rd_sel)); end
        if (obs_sat[k] !== m_sat[k]) begin errs++; $display("FAIL rand_sat c%0d dut%0d got=%b want=%b", c, k, obs_sat[k], m_sat[k]); end
        if (obs_st[k] !== m_st) begin errs++; $display("FAIL rand_state c%0d dut%0d got=%b want=%b", c, k, obs_st[k], m_st); end
      end
    end
    {tick, start, halt, clr, snap, inc} = '0;
  endtask
  initial begin
    test_reset();
    test_count();
    test_halt();
    test_overflow();
    test_snap_clr();
    test_tick_gate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
